// File: rtl/adler32_pkg.sv
// Shared definitions for the adler32 byte feeder and its bench:
// FSM state encoding, minimum idle gap, Adler-32 modulus and the
// per-word byte-count helper.
package adler32_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // adler32 needs one cycle for checksum_valid and one for its internal reset.
   localparam int ADLER32_MIN_GAP = 2;

   // Largest prime below 2^16; used by the reference checksum model.
   localparam int ADLER32_MOD = 65521;

   // Number of bytes to emit from a captured word: a full word unless it is
   // the final word of the message, where in_bytes holds (count - 1).
   function automatic logic [2:0] word_byte_count(input logic last, input logic [1:0] nbytes);
      return last ? ({1'b0, nbytes} + 3'd1) : 3'd4;
   endfunction

endpackage

// File: rtl/adler32_byte_feeder_byte_shifter.sv
// byte_shifter: 32-bit load/shift register with a remaining-byte counter.
// Presents the current byte and flags when it is the last one of the word.
// MSB_FIRST selects whether bytes leave from the top or the bottom lane.
module byte_shifter #(
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        load,
   input  logic        shift,
   input  logic [31:0] load_data,
   input  logic [2:0]  load_count,
   output logic [7:0]  cur_byte,
   output logic        final_byte
);

   logic [31:0] sreg;
   logic [2:0]  count;

   // Load has priority so a reload on the final byte gives back-to-back output.
   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         sreg  <= '0;
         count <= '0;
      end else if (load) begin
         sreg  <= load_data;
         count <= load_count;
      end else if (shift && (count != 3'd0)) begin
         if (MSB_FIRST) begin
            sreg <= {sreg[23:0], 8'h00};
         end else begin
            sreg <= {8'h00, sreg[31:8]};
         end
         count <= count - 3'd1;
      end
   end

   assign cur_byte   = MSB_FIRST ? sreg[31:24] : sreg[7:0];
   assign final_byte = (count == 3'd1);

endmodule

// File: rtl/adler32_byte_feeder.sv
// adler32_byte_feeder: serialises 32-bit message words into one byte per
// cycle for adler32, flags the final byte, then holds off the next message
// for GAP_CYCLES idle cycles.
// Optional build macro ADLER32_FEEDER_LEN_EN adds a msg_len byte counter.
module adler32_byte_feeder
   import adler32_pkg::*;
#(
   parameter int GAP_CYCLES = 2,
   parameter bit MSB_FIRST  = 1'b0
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic [1:0]  in_bytes,
   output logic [7:0]  data,
   output logic        data_valid,
   output logic        last_data,
   output logic        busy
`ifdef ADLER32_FEEDER_LEN_EN
   ,
   output logic [31:0] msg_len
`endif
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   if (GAP_CYCLES < ADLER32_MIN_GAP) begin : g_gap_check
      $error("adler32_byte_feeder: GAP_CYCLES must be at least ADLER32_MIN_GAP");
   end

   state_t             state;
   logic               last_word;
   logic [GAP_W-1:0]   gap_cnt;
   logic [7:0]         cur_byte;
   logic               final_byte;
   logic               accept;
   logic               shift_en;

   byte_shifter #(
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clock      (clock),
      .rst        (rst),
      .load       (accept),
      .shift      (shift_en),
      .load_data  (in_data),
      .load_count (word_byte_count(in_last, in_bytes)),
      .cur_byte   (cur_byte),
      .final_byte (final_byte)
   );

   // NOTE: in_ready is gated by rst so no word can be accepted on the reset edge.
   assign in_ready = !rst &&
                     ((state == IDLE) ||
                      ((state == SHIFT) && final_byte && !last_word));
   assign accept   = in_valid && in_ready;
   assign shift_en = (state == SHIFT);

   // Byte-side outputs decode registered state only, never the upstream inputs.
   assign data_valid = (state == SHIFT);
   assign data       = data_valid ? cur_byte : 8'h00;
   assign last_data  = data_valid && final_byte && last_word;
   assign busy       = (state != IDLE);

   // Sequencer: IDLE -> SHIFT on accept, SHIFT chains words or ends in GAP.
   always_ff @(posedge clock) begin
      if (rst) begin
         state     <= IDLE;
         last_word <= 1'b0;
         gap_cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  state     <= SHIFT;
                  last_word <= in_last;
               end
            end
            SHIFT: begin
               if (final_byte) begin
                  if (last_word) begin
                     state   <= GAP;
                     gap_cnt <= '0;
                  end else if (accept) begin
                     last_word <= in_last;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ADLER32_FEEDER_LEN_EN
   logic [31:0] len_q;
   logic        new_msg;

   // msg_len includes the byte on data this cycle; it restarts at 1 on the
   // first byte after a last_data and otherwise holds between messages.
   assign msg_len = data_valid ? (new_msg ? 32'd1 : len_q + 32'd1) : len_q;

   // Track the running length and whether the next byte opens a new message.
   always_ff @(posedge clock) begin
      if (rst) begin
         len_q   <= '0;
         new_msg <= 1'b1;
      end else if (data_valid) begin
         len_q   <= msg_len;
         new_msg <= last_data;
      end
   end
`endif

endmodule
